dplca_txop_table_ctrl: RTL and testbench
========================================

DPLCA_TXOP_TABLE_CTRL -- requirements
Module: dplca_txop_table_ctrl

Interface
REQ-001 Parameter TXOP_COUNT, default 256: number of TXOP claim-table entries.
REQ-002 Parameter NO_TXOP, default 8'd255: value reported when no free TXOP exists.
REQ-003 clk  in  1  single clock; all logic is rising-edge.
REQ-004 plca_reset_n  in  1  synchronous, active-low reset.
REQ-005 dplca_aging  in  1  enables table maintenance; 0 forces DISABLED.
REQ-006 dplca_age_cycles  in  4  aging period in PLCA cycles; 0 is treated as 1.
REQ-007 txop_busy_valid  in  1  one-clock strobe: transmission observed in a TXOP.
REQ-008 txop_busy_id  in  8  TXOP id for txop_busy_valid.
REQ-009 cycle_end  in  1  one-clock strobe at BEACON (PLCA cycle boundary).
REQ-010 txop_claim_table_unpacked  out  512  entry i at bits [2i+1:2i].
REQ-011 dplca_txop_table_upd  out  1  one-clock pulse when a table update completes.
REQ-012 dplca_new_age  out  1  level: the last completed update applied aging.
REQ-013 max_hard_claim  out  8  highest HARD_CLAIMED index; 0 if none.
REQ-014 free_txop  out  8  lowest UNCLAIMED index >= 1; NO_TXOP if none.
REQ-015 sweep_overrun  out  1  sticky: cycle_end arrived during SWEEP.

Function
REQ-016 Entry encoding SHALL be 2'b00 UNCLAIMED, 2'b01 SOFT_CLAIMED, 2'b10 HARD_CLAIMED; 2'b11 reserved, never written.
REQ-017 FSM states SHALL be DISABLED, COLLECT, SWEEP, DONE.
REQ-018 DISABLED -> COLLECT when dplca_aging=1; any state -> DISABLED on the clock after dplca_aging=0, including mid-SWEEP.
REQ-019 In COLLECT and SWEEP, txop_busy_valid SHALL set bit txop_busy_id of a 256-bit seen vector; strobes are ignored in DISABLED.
REQ-020 On cycle_end in COLLECT, the seen vector (including a same-clock busy strobe) SHALL be snapshotted, the live seen vector cleared, and the FSM SHALL enter SWEEP.
REQ-021 Age counter SHALL increment on each accepted cycle_end; a sweep is an aging sweep when counter == max(dplca_age_cycles,1)-1, and the counter then wraps to 0.
REQ-022 SWEEP SHALL process one entry per clock, index 0..255, in a working table copy: seen -> HARD_CLAIMED; else if aging sweep, HARD -> SOFT and SOFT -> UNCLAIMED; else unchanged.
REQ-023 During SWEEP, max_hard_claim and free_txop candidates SHALL be accumulated from new entry values; index 0 is never a free candidate.
REQ-024 With cycle_end accepted at clock T, entries SHALL be processed at T+1..T+256; DONE at T+257 publishes the table, max_hard_claim, free_txop, and dplca_new_age, and pulses dplca_txop_table_upd; COLLECT resumes at T+258.
REQ-025 cycle_end during SWEEP or DONE SHALL be ignored and SHALL set sweep_overrun; the age counter is not incremented.
REQ-026 Index counter SHALL be 8 bits; the sweep SHALL end on the wrap from 255, with no 9-bit overflow.
REQ-027 Published outputs SHALL hold their values between DONE pulses.

Reset
REQ-028 On plca_reset_n=0 at a clock edge: state DISABLED, table all UNCLAIMED, seen vectors and age counter 0, dplca_txop_table_upd 0, dplca_new_age 0, max_hard_claim 0, free_txop 1, sweep_overrun 0.
REQ-029 Entry to DISABLED through dplca_aging=0 SHALL apply the same values as REQ-028.

Structure
REQ-030 Shared package dplca_pkg SHALL hold the claim encodings, TXOP_COUNT, NO_TXOP, and the FSM state enumeration.
REQ-031 The age counter SHALL be a sub-module, dplca_age_cnt, with inputs clr, inc, and period, and output aging_now.

Verification
REQ-032 Reset, set dplca_aging=1, send busy on ids 3 and 7, then cycle_end at T -> upd pulse at T+257; entries 3 and 7 are HARD; max_hard_claim=7; free_txop=1.
REQ-033 dplca_age_cycles=2, id 5 busy only in cycle 1, then three cycle_ends -> entry 5 goes HARD, then SOFT with new_age=1, then HARD retained only if seen, otherwise UNCLAIMED after the next aging sweep.
REQ-034 Busy on ids 1..254, then cycle_end -> free_txop=255 (NO_TXOP) and max_hard_claim=254.
REQ-035 busy_valid id 9 in the same clock as cycle_end -> entry 9 is HARD after this sweep; the live seen vector is clear.
REQ-036 cycle_end at T+100 during SWEEP -> sweep_overrun=1, exactly one upd pulse, age counter unchanged.
REQ-037 dplca_aging=0 at T+50 mid-SWEEP -> DISABLED next clock, table all UNCLAIMED, no upd pulse.

Source files
------------

// File: rtl/dplca_pkg.sv
// dplca_pkg: shared claim encodings, table geometry and FSM states for the DPLCA TXOP table
package dplca_pkg;
    localparam int TXOP_COUNT = 256;
    localparam logic [7:0] NO_TXOP = 8'd255;
    typedef enum logic [1:0] {
        UNCLAIMED    = 2'b00,
        SOFT_CLAIMED = 2'b01,
        HARD_CLAIMED = 2'b10
    } claim_e;
    typedef enum logic [1:0] {
        DISABLED,
        COLLECT,
        SWEEP,
        DONE
    } state_e;
endpackage

// File: rtl/dplca_txop_table_ctrl_if.sv
// dplca_txop_table_ctrl_if: busy/cycle strobes in, published claim table and status out
// master: drives txop_busy_valid/txop_busy_id/cycle_end, observes the published results
// slave : the table controller
interface dplca_txop_table_ctrl_if;
    import dplca_pkg::*;
    logic                    txop_busy_valid;
    logic [7:0]              txop_busy_id;
    logic                    cycle_end;
    logic [2*TXOP_COUNT-1:0] txop_claim_table_unpacked;
    logic                    dplca_txop_table_upd;
    logic                    dplca_new_age;
    logic [7:0]              max_hard_claim;
    logic [7:0]              free_txop;
    logic                    sweep_overrun;
    modport master (
        output txop_busy_valid, txop_busy_id, cycle_end,
        input  txop_claim_table_unpacked, dplca_txop_table_upd, dplca_new_age,
               max_hard_claim, free_txop, sweep_overrun
    );
    modport slave (
        input  txop_busy_valid, txop_busy_id, cycle_end,
        output txop_claim_table_unpacked, dplca_txop_table_upd, dplca_new_age,
               max_hard_claim, free_txop, sweep_overrun
    );
endinterface

// File: rtl/dplca_age_cnt.sv
// dplca_age_cnt: counts accepted PLCA cycles and flags the one whose sweep must age the table
// clk, clr (sync clear), inc (accepted cycle_end), period (0 acts as 1), aging_now (this cycle ages)
module dplca_age_cnt (
    input  logic       clk,
    input  logic       clr,
    input  logic       inc,
    input  logic [3:0] period,
    output logic       aging_now
);
    logic [3:0] cnt, last;
    assign last = (period == 4'd0 ? 4'd1 : period) - 4'd1;
    // >= keeps the counter from running away if period shrinks below the current count
    assign aging_now = cnt >= last;
    always_ff @(posedge clk)
        if (clr) cnt <= '0;
        else if (inc) cnt <= aging_now ? 4'd0 : cnt + 4'd1;
endmodule

// File: rtl/dplca_txop_table_ctrl.sv
// dplca_txop_table_ctrl: collects busy TXOPs per PLCA cycle and sweeps them into a claim table
// clk, plca_reset_n (sync, active-low), dplca_aging (enable), dplca_age_cycles (aging period),
// bus (slave): busy/cycle_end strobes in; table, upd pulse, new_age, max_hard_claim, free_txop, sweep_overrun out
module dplca_txop_table_ctrl
    import dplca_pkg::*;
#(
    parameter int         TXOP_COUNT = dplca_pkg::TXOP_COUNT,
    parameter logic [7:0] NO_TXOP    = dplca_pkg::NO_TXOP
) (
    input  logic                           clk,
    input  logic                           plca_reset_n,
    input  logic                           dplca_aging,
    input  logic [3:0]                     dplca_age_cycles,
    dplca_txop_table_ctrl_if.slave         bus
);
    state_e                  state;
    logic [TXOP_COUNT-1:0]   seen, snap, busy_hot;
    logic [2*TXOP_COUNT-1:0] work, tbl;
    logic [7:0]              idx, max_acc, free_acc, max_q, free_q;
    logic                    free_hit, aging_sweep, aging_now, clr, accept;
    logic                    upd_q, new_age_q, overrun_q;
    logic [1:0]              cur, nxt;
    assign clr      = !plca_reset_n || !dplca_aging;
    assign accept   = state == COLLECT && bus.cycle_end;
    assign busy_hot = bus.txop_busy_valid ? TXOP_COUNT'(1) << bus.txop_busy_id : '0;
    assign cur      = work[{idx, 1'b0} +: 2];
    // aging demotes HARD to SOFT and everything else to UNCLAIMED
    assign nxt = snap[idx] ? HARD_CLAIMED : !aging_sweep ? cur :
                 cur == HARD_CLAIMED ? SOFT_CLAIMED : UNCLAIMED;
    dplca_age_cnt u_age (
        .clk      (clk),
        .clr      (clr),
        .inc      (accept),
        .period   (dplca_age_cycles),
        .aging_now(aging_now)
    );
    always_ff @(posedge clk) begin
        if (clr) begin
            state       <= DISABLED;
            seen        <= '0;
            snap        <= '0;
            work        <= '0;
            tbl         <= '0;
            idx         <= '0;
            max_acc     <= '0;
            free_acc    <= NO_TXOP;
            free_hit    <= 1'b0;
            aging_sweep <= 1'b0;
            upd_q       <= 1'b0;
            new_age_q   <= 1'b0;
            max_q       <= '0;
            free_q      <= 8'd1;
            overrun_q   <= 1'b0;
        end else begin
            upd_q <= 1'b0;
            if (state == COLLECT || state == SWEEP) seen <= seen | busy_hot;
            if ((state == SWEEP || state == DONE) && bus.cycle_end) overrun_q <= 1'b1;
            case (state)
                DISABLED: state <= COLLECT;
                COLLECT: if (bus.cycle_end) begin
                    // a busy strobe on the boundary clock belongs to the closing cycle
                    snap        <= seen | busy_hot;
                    seen        <= '0;
                    work        <= tbl;
                    idx         <= '0;
                    max_acc     <= '0;
                    free_acc    <= NO_TXOP;
                    free_hit    <= 1'b0;
                    aging_sweep <= aging_now;
                    state       <= SWEEP;
                end
                SWEEP: begin
                    work[{idx, 1'b0} +: 2] <= nxt;
                    if (nxt == HARD_CLAIMED) max_acc <= idx;
                    if (nxt == UNCLAIMED && idx != 8'd0 && !free_hit) begin
                        free_acc <= idx;
                        free_hit <= 1'b1;
                    end
                    idx <= idx + 8'd1;
                    if (idx == 8'(TXOP_COUNT - 1)) state <= DONE;
                end
                DONE: begin
                    tbl       <= work;
                    max_q     <= max_acc;
                    free_q    <= free_acc;
                    new_age_q <= aging_sweep;
                    upd_q     <= 1'b1;
                    state     <= COLLECT;
                end
            endcase
        end
    end
    assign bus.txop_claim_table_unpacked = tbl;
    assign bus.dplca_txop_table_upd      = upd_q;
    assign bus.dplca_new_age             = new_age_q;
    assign bus.max_hard_claim            = max_q;
    assign bus.free_txop                 = free_q;
    assign bus.sweep_overrun             = overrun_q;
endmodule

// File: tb/tb_dplca_txop_table_ctrl.sv
// tb_dplca_txop_table_ctrl: directed scoreboard bench for the TXOP claim-table controller
module tb_dplca_txop_table_ctrl;
    import dplca_pkg::*;
    typedef struct {
        logic [511:0] tbl;
        logic [7:0]   max_h;
        logic [7:0]   free;
        logic         new_age;
    } exp_t;
    logic       clk = 1'b0;
    logic       plca_reset_n;
    logic       dplca_aging;
    logic [3:0] dplca_age_cycles;
    dplca_txop_table_ctrl_if bus();
    dplca_txop_table_ctrl dut (
        .clk             (clk),
        .plca_reset_n    (plca_reset_n),
        .dplca_aging     (dplca_aging),
        .dplca_age_cycles(dplca_age_cycles),
        .bus             (bus)
    );
    always #5 clk = ~clk;
    exp_t       q[$];
    logic [1:0] m_tbl[256];
    bit         m_seen[256];
    int         m_cnt;
    logic       m_ovr;
    int         checks = 0;
    int         failures = 0;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    function automatic logic [511:0] pack_tbl();
        logic [511:0] v;
        for (int i = 0; i < 256; i++) v[2*i +: 2] = m_tbl[i];
        return v;
    endfunction
    task automatic model_reset();
        for (int i = 0; i < 256; i++) begin
            m_tbl[i]  = 2'b00;
            m_seen[i] = 1'b0;
        end
        m_cnt = 0;
        m_ovr = 1'b0;
        q.delete();
    endtask
    task automatic check_idle(input string tag);
        check({tag, "_table"}, bus.txop_claim_table_unpacked, '0);
        check({tag, "_max"}, bus.max_hard_claim, 8'd0);
        check({tag, "_free"}, bus.free_txop, 8'd1);
        check({tag, "_new_age"}, bus.dplca_new_age, 1'b0);
        check({tag, "_overrun"}, bus.sweep_overrun, 1'b0);
        check({tag, "_upd"}, bus.dplca_txop_table_upd, 1'b0);
    endtask
    task automatic do_reset(input logic [3:0] ac);
        dplca_age_cycles = ac;
        plca_reset_n = 1'b0;
        tick();
        tick();
        plca_reset_n = 1'b1;
        tick();
        model_reset();
    endtask
    task automatic busy(input int id);
        bus.txop_busy_valid = 1'b1;
        bus.txop_busy_id = 8'(id);
        m_seen[id] = 1'b1;
        tick();
        bus.txop_busy_valid = 1'b0;
    endtask
    // wb: busy strobe on the cycle_end clock; ovr_at/abort_at: clocks after T for overrun / disable
    task automatic end_cycle(input string tag, input bit wb, input int id, input int ovr_at, input int abort_at);
        exp_t e, r;
        bit   aging;
        int   eff, pulses, first;
        pulses = 0;
        first = 0;
        if (wb) m_seen[id] = 1'b1;
        eff = dplca_age_cycles == 4'd0 ? 1 : int'(dplca_age_cycles);
        aging = m_cnt == eff - 1;
        m_cnt = aging ? 0 : m_cnt + 1;
        e.max_h = 8'd0;
        e.free = 8'd255;
        e.new_age = aging;
        for (int i = 0; i < 256; i++) begin
            if (m_seen[i]) m_tbl[i] = 2'b10;
            else if (aging) m_tbl[i] = m_tbl[i] == 2'b10 ? 2'b01 : 2'b00;
            m_seen[i] = 1'b0;
            if (m_tbl[i] == 2'b10) e.max_h = 8'(i);
        end
        for (int i = 255; i >= 1; i--) if (m_tbl[i] == 2'b00) e.free = 8'(i);
        e.tbl = pack_tbl();
        q.push_back(e);
        if (ovr_at != 0) m_ovr = 1'b1;
        bus.cycle_end = 1'b1;
        if (wb) begin
            bus.txop_busy_valid = 1'b1;
            bus.txop_busy_id = 8'(id);
        end
        tick();
        bus.cycle_end = 1'b0;
        bus.txop_busy_valid = 1'b0;
        for (int n = 1; n <= 400; n++) begin
            if (n == ovr_at) bus.cycle_end = 1'b1;
            if (n == abort_at) dplca_aging = 1'b0;
            tick();
            bus.cycle_end = 1'b0;
            if (n == abort_at) begin
                check_idle({tag, "_abort"});
                model_reset();
            end
            if (bus.dplca_txop_table_upd === 1'b1) begin
                pulses++;
                if (first == 0) begin
                    first = n;
                    if (q.size() > 0) begin
                        r = q.pop_front();
                        check({tag, "_table"}, bus.txop_claim_table_unpacked, r.tbl);
                        check({tag, "_max"}, bus.max_hard_claim, r.max_h);
                        check({tag, "_free"}, bus.free_txop, r.free);
                        check({tag, "_new_age"}, bus.dplca_new_age, r.new_age);
                    end
                end
            end
        end
        check({tag, "_upd_count"}, 512'(pulses), abort_at != 0 ? 512'd0 : 512'd1);
        if (abort_at == 0) check({tag, "_upd_time"}, 512'(first), 512'd257);
        check({tag, "_overrun"}, bus.sweep_overrun, m_ovr);
        if (abort_at != 0) begin
            dplca_aging = 1'b1;
            tick();
        end
    endtask
    initial begin
        plca_reset_n = 1'b0;
        dplca_aging = 1'b1;
        dplca_age_cycles = 4'd4;
        bus.txop_busy_valid = 1'b0;
        bus.txop_busy_id = 8'd0;
        bus.cycle_end = 1'b0;
        tick();
        tick();
        check_idle("reset");
        do_reset(4'd4);
        busy(3);
        busy(7);
        end_cycle("basic", 1'b0, 0, 0, 0);
        check("basic_hold_table", bus.txop_claim_table_unpacked, pack_tbl());
        do_reset(4'd2);
        busy(5);
        end_cycle("age1", 1'b0, 0, 0, 0);
        end_cycle("age2", 1'b0, 0, 0, 0);
        end_cycle("age3", 1'b0, 0, 0, 0);
        end_cycle("age4", 1'b0, 0, 0, 0);
        busy(5);
        end_cycle("age5", 1'b0, 0, 0, 0);
        end_cycle("age6", 1'b0, 0, 0, 0);
        do_reset(4'd15);
        for (int i = 1; i <= 254; i++) busy(i);
        end_cycle("full254", 1'b0, 0, 0, 0);
        busy(255);
        end_cycle("full255", 1'b0, 0, 0, 0);
        do_reset(4'd0);
        end_cycle("same_clk", 1'b1, 9, 0, 0);
        end_cycle("same_clk_next", 1'b0, 0, 0, 0);
        do_reset(4'd2);
        busy(4);
        end_cycle("overrun", 1'b0, 0, 100, 0);
        end_cycle("overrun_next", 1'b0, 0, 0, 0);
        busy(6);
        end_cycle("abort", 1'b0, 0, 0, 50);
        busy(2);
        end_cycle("after_abort", 1'b0, 0, 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
